// File: rtl/robot_pkg.sv
// Shared definitions for the robot motion path: motor drive encoding and
// the sequencer state type.
package robot_pkg;

    localparam logic [1:0] MOT_STOP = 2'b00;
    localparam logic [1:0] MOT_FWD  = 2'b01;
    localparam logic [1:0] MOT_REV  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FWD,
        ST_TURN,
        ST_SETTLE,
        ST_DONE
    } seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter for move phases; holds at zero and flags it so the
// sequencer can leave the current phase.
module phase_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/motion_sequencer.sv
// Turns one-hot navigation commands into timed drive + settle phases, pulses
// step_done at the end of each move and counts completed moves.
module motion_sequencer
    import robot_pkg::*;
#(
    parameter int FWD_CYCLES    = 8,
    parameter int TURN_CYCLES   = 12,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       front,
    input  logic       turn,
    output logic [1:0] motor_left,
    output logic [1:0] motor_right,
    output logic       busy,
    output logic       step_done,
    output logic [7:0] move_count
);

    localparam int MAX_CYCLES = max3(FWD_CYCLES, TURN_CYCLES, SETTLE_CYCLES);
    localparam int TW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [TW-1:0] FWD_LOAD    = TW'(FWD_CYCLES - 1);
    localparam logic [TW-1:0] TURN_LOAD   = TW'(TURN_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

    seq_state_t    state;
    logic          accept_turn;
    logic          accept_fwd;
    logic          timer_load;
    logic [TW-1:0] timer_value;
    logic          timer_zero;

    // Turn wins when both command bits are present.
    assign accept_turn = enable && turn;
    assign accept_fwd  = enable && front && !turn;

    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        unique case (state)
            ST_IDLE: begin
                if (accept_turn) begin
                    timer_load  = 1'b1;
                    timer_value = TURN_LOAD;
                end else if (accept_fwd) begin
                    timer_load  = 1'b1;
                    timer_value = FWD_LOAD;
                end
            end
            ST_FWD, ST_TURN: begin
                if (timer_zero) begin
                    timer_load  = 1'b1;
                    timer_value = SETTLE_LOAD;
                end
            end
            default: ;
        endcase
    end

    phase_timer #(
        .WIDTH(TW)
    ) u_phase_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    // Outputs are set on the same edge as the state change so they always
    // reflect the state being entered, never the live inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            motor_left  <= MOT_STOP;
            motor_right <= MOT_STOP;
            busy        <= 1'b0;
            step_done   <= 1'b0;
            move_count  <= 8'd0;
        end else begin
            step_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept_turn) begin
                        state       <= ST_TURN;
                        motor_left  <= MOT_FWD;
                        motor_right <= MOT_REV;
                        busy        <= 1'b1;
                    end else if (accept_fwd) begin
                        state       <= ST_FWD;
                        motor_left  <= MOT_FWD;
                        motor_right <= MOT_FWD;
                        busy        <= 1'b1;
                    end
                end
                ST_FWD, ST_TURN: begin
                    if (timer_zero) begin
                        state       <= ST_SETTLE;
                        motor_left  <= MOT_STOP;
                        motor_right <= MOT_STOP;
                    end
                end
                ST_SETTLE: begin
                    if (timer_zero) begin
                        state      <= ST_DONE;
                        step_done  <= 1'b1;
                        move_count <= move_count + 8'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state       <= ST_IDLE;
                    motor_left  <= MOT_STOP;
                    motor_right <= MOT_STOP;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motion_sequencer.sv
// Bench for motion_sequencer: a cycle model feeds a scoreboard queue, plus a
// command table and hand-written sequences for the multi-cycle corner cases.
module tb_motion_sequencer;

    localparam int FWD_N  = 4;
    localparam int TURN_N = 6;
    localparam int SET_N  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       front;
    logic       turn;
    logic [1:0] motor_left;
    logic [1:0] motor_right;
    logic       busy;
    logic       step_done;
    logic [7:0] move_count;

    always #5 clk = ~clk;

    motion_sequencer #(
        .FWD_CYCLES    (FWD_N),
        .TURN_CYCLES   (TURN_N),
        .SETTLE_CYCLES (SET_N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .front       (front),
        .turn        (turn),
        .motor_left  (motor_left),
        .motor_right (motor_right),
        .busy        (busy),
        .step_done   (step_done),
        .move_count  (move_count)
    );

    typedef struct packed {
        logic [1:0] ml;
        logic [1:0] mr;
        logic       bsy;
        logic       done;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        logic en;
        logic f;
        logic t;
        int   exp_fwd;
        int   exp_turn;
        int   exp_done;
    } vec_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: phase 0 idle, 1 drive, 2 settle, 3 done.
    int         m_phase = 0;
    int         m_el    = 0;
    int         m_len   = 0;
    logic [1:0] m_ml    = 2'b00;
    logic [1:0] m_mr    = 2'b00;
    logic [7:0] m_count = 8'd0;

    int obs_fwd, obs_turn, obs_done;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_el    = 0;
        m_len   = 0;
        m_ml    = 2'b00;
        m_mr    = 2'b00;
        m_count = 8'd0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            case (m_phase)
                0: begin
                    if (enable && turn) begin
                        m_phase = 1; m_ml = 2'b01; m_mr = 2'b10; m_len = TURN_N; m_el = 1;
                    end else if (enable && front) begin
                        m_phase = 1; m_ml = 2'b01; m_mr = 2'b01; m_len = FWD_N; m_el = 1;
                    end
                end
                1: begin
                    if (m_el == m_len) begin
                        m_phase = 2; m_len = SET_N; m_el = 1;
                    end else begin
                        m_el++;
                    end
                end
                2: begin
                    if (m_el == m_len) begin
                        m_phase = 3; m_count = m_count + 8'd1;
                    end else begin
                        m_el++;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    function automatic exp_t model_out();
        exp_t o;
        o.ml   = (m_phase == 1) ? m_ml : 2'b00;
        o.mr   = (m_phase == 1) ? m_mr : 2'b00;
        o.bsy  = (m_phase != 0);
        o.done = (m_phase == 3);
        o.cnt  = m_count;
        return o;
    endfunction

    // One clock: drive at negedge, push the model's prediction, compare after
    // the rising edge.
    task automatic step(input logic en, input logic f, input logic t);
        exp_t e;
        exp_t got;
        @(negedge clk);
        enable = en;
        front  = f;
        turn   = t;
        model_edge();
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        got = '{motor_left, motor_right, busy, step_done, move_count};
        e   = sb_q.pop_front();
        check("cycle {ml,mr,busy,done,cnt}", int'(got), int'(e));
        if (motor_left == 2'b01 && motor_right == 2'b01) obs_fwd++;
        if (motor_left == 2'b01 && motor_right == 2'b10) obs_turn++;
        if (step_done) obs_done++;
    endtask

    task automatic clear_obs();
        obs_fwd  = 0;
        obs_turn = 0;
        obs_done = 0;
    endtask

    vec_t       vecs[6];
    logic [7:0] cnt_before;
    int         last_done;
    int         n_done;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, FWD_N, 0,      1};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 0,     TURN_N, 1};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 0,     TURN_N, 1};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 0,     0,      0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 0,     0,      0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 0,     0,      0};

        rst_n  = 1'b0;
        enable = 1'b0;
        front  = 1'b0;
        turn   = 1'b0;
        clear_obs();
        #2;
        check("reset outputs", int'({motor_left, motor_right, busy, step_done, move_count}), 0);
        step(0, 0, 0);
        step(1, 1, 1);
        rst_n = 1'b1;

        // Command table: one-cycle command then idle inputs.
        foreach (vecs[i]) begin
            clear_obs();
            cnt_before = move_count;
            step(vecs[i].en, vecs[i].f, vecs[i].t);
            for (int k = 0; k < 12; k++) step(vecs[i].en, 1'b0, 1'b0);
            check($sformatf("vec%0d fwd cycles", i), obs_fwd, vecs[i].exp_fwd);
            check($sformatf("vec%0d turn cycles", i), obs_turn, vecs[i].exp_turn);
            check($sformatf("vec%0d step_done pulses", i), obs_done, vecs[i].exp_done);
            check($sformatf("vec%0d count delta", i), int'(move_count - cnt_before), vecs[i].exp_done);
        end

        // Turn pulsed during a forward move is ignored and not queued.
        clear_obs();
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 0, 1);
        for (int k = 0; k < 12; k++) step(1, 1'b0, 1'b0);
        check("ignore fwd cycles", obs_fwd, FWD_N);
        check("ignore turn cycles", obs_turn, 0);
        check("ignore step_done pulses", obs_done, 1);
        check("ignore back to idle", int'(busy), 0);

        // Enable dropped mid-turn: turn completes, then stays idle.
        clear_obs();
        step(1, 0, 1);
        step(1, 0, 1);
        for (int k = 0; k < 16; k++) step(0, 1'b0, 1'b1);
        check("endrop turn cycles", obs_turn, TURN_N);
        check("endrop step_done pulses", obs_done, 1);
        check("endrop idle after", int'(busy), 0);

        // Reset on the third turn cycle.
        clear_obs();
        step(1, 0, 1);
        step(1, 0, 0);
        step(1, 0, 0);
        check("pre-reset turning", int'({motor_left, motor_right}), 4'b0110);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset motors", int'({motor_left, motor_right}), 0);
        check("async reset count", int'(move_count), 0);
        check("async reset busy/done", int'({busy, step_done}), 0);
        sb_q.delete();
        model_reset();
        step(1, 0, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) step(1, 1'b0, 1'b0);
        check("no done after reset", obs_done, 0);
        clear_obs();
        step(1, 1, 0);
        for (int k = 0; k < 9; k++) step(1, 1'b0, 1'b0);
        check("post-reset fwd cycles", obs_fwd, FWD_N);
        check("post-reset count", int'(move_count), 1);

        // Back-to-back with front held: period 8, count wraps on move 256.
        rst_n = 1'b0;
        model_reset();
        sb_q.delete();
        step(0, 0, 0);
        rst_n     = 1'b1;
        last_done = -1;
        n_done    = 0;
        for (int c = 0; c < 256 * 8 + 4; c++) begin
            step(1, 1, 0);
            if (step_done) begin
                n_done++;
                if (last_done >= 0) check("b2b period", c - last_done, FWD_N + SET_N + 2);
                last_done = c;
                if (n_done == 255) check("count at 255th", int'(move_count), 255);
                if (n_done == 256) check("count wrap at 256th", int'(move_count), 0);
            end
        end
        check("b2b total pulses", n_done, 256);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
